// File: rtl/multi_cycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multi_cycle_control
//  Purpose  : Control FSM for a multi-cycle RV32I datapath. It walks each
//             instruction through FETCH / DECODE / EXECUTE / MEM / WB. It
//             halts on an unsupported opcode or on a data-memory timeout.
//  Ports    : iClk, iRst (async, active-high)
//             iInst_Code   - instruction at current PC
//             iBtaken      - branch compare result from the ALU
//             iData_Ack    - data memory completes the pending access
//             oIR_En, oPC_En, oPC_Sel          - IR / PC load control
//             oALU_Control, oALUSrcMuxSel1/2   - ALU operation and operands
//             oRegWrDataSel, oRegWrEn          - register file write-back
//             oData_Req, oData_WrEn, oData_Size - data memory access
//             oIllegal, oBusErr                - sticky halt reasons
//  Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_control #(
  parameter int DATA_TIMEOUT = 16
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iInst_Code,
  input  logic        iBtaken,
  input  logic        iData_Ack,
  output logic        oIR_En,
  output logic        oPC_En,
  output logic [1:0]  oPC_Sel,
  output logic [3:0]  oALU_Control,
  output logic        oALUSrcMuxSel1,
  output logic        oALUSrcMuxSel2,
  output logic [1:0]  oRegWrDataSel,
  output logic        oRegWrEn,
  output logic        oData_Req,
  output logic        oData_WrEn,
  output logic [2:0]  oData_Size,
  output logic        oIllegal,
  output logic        oBusErr
);

  localparam int CNT_W = (DATA_TIMEOUT > 1) ? $clog2(DATA_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_TIMEOUT - 1);

  localparam logic [6:0] c_OP_R     = 7'b0110011;
  localparam logic [6:0] c_OP_IL    = 7'b0000011;
  localparam logic [6:0] c_OP_I     = 7'b0010011;
  localparam logic [6:0] c_OP_S     = 7'b0100011;
  localparam logic [6:0] c_OP_B     = 7'b1100011;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [6:0]       r_opcode;
  logic [2:0]       r_funct3;
  logic             r_f7b5;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal;
  logic             r_buserr;
  logic             w_set_illegal;
  logic             w_set_buserr;

  // Only opcode, funct3 and funct7[5] steer control; the register and
  // immediate fields belong to the datapath.
  logic w_unused_inst;
  assign w_unused_inst = &{1'b0, iInst_Code[31], iInst_Code[29:15], iInst_Code[11:7]};

  // Instruction class, decoded from the latched opcode only.
  logic w_is_r, w_is_il, w_is_i, w_is_s, w_is_b;
  logic w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_legal;

  assign w_is_r     = (r_opcode == c_OP_R);
  assign w_is_il    = (r_opcode == c_OP_IL);
  assign w_is_i     = (r_opcode == c_OP_I);
  assign w_is_s     = (r_opcode == c_OP_S);
  assign w_is_b     = (r_opcode == c_OP_B);
  assign w_is_lui   = (r_opcode == c_OP_LUI);
  assign w_is_auipc = (r_opcode == c_OP_AUIPC);
  assign w_is_jal   = (r_opcode == c_OP_JAL);
  assign w_is_jalr  = (r_opcode == c_OP_JALR);
  assign w_legal    = w_is_r | w_is_il | w_is_i | w_is_s | w_is_b |
                      w_is_lui | w_is_auipc | w_is_jal | w_is_jalr;

  // State, latched instruction fields, MEM cycle counter and sticky flags.
  // The async reset clears the latched fields too, so every select derived
  // from them drops to zero the moment iRst rises.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state   <= ST_FETCH;
      r_opcode  <= 7'd0;
      r_funct3  <= 3'd0;
      r_f7b5    <= 1'b0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_buserr  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FETCH) begin
        r_opcode <= iInst_Code[6:0];
        r_funct3 <= iInst_Code[14:12];
        r_f7b5   <= iInst_Code[30];
      end
      // MEM is always entered from EXECUTE, so the counter is zero on entry.
      if (r_state == ST_MEM) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
      if (w_set_buserr) begin
        r_buserr <= 1'b1;
      end
    end
  end

  // Datapath selects: functions of the latched instruction alone, so they
  // stay stable for the whole instruction. The branch PC select is the one
  // exception; it follows iBtaken during the EXECUTE cycle that loads the PC.
  always_comb begin
    oALU_Control   = 4'b0000;
    oALUSrcMuxSel1 = w_is_auipc;
    oALUSrcMuxSel2 = w_is_i | w_is_il | w_is_s | w_is_jalr | w_is_auipc;
    oRegWrDataSel  = 2'd0;
    oPC_Sel        = 2'd0;
    oData_Size     = r_funct3;

    if (w_is_r) begin
      oALU_Control = {r_f7b5, r_funct3};
    end else if (w_is_i) begin
      // Only SRLI/SRAI use funct7[5]; other immediates reuse those bits.
      oALU_Control = {(r_funct3 == 3'b101) ? r_f7b5 : 1'b0, r_funct3};
    end else if (w_is_b) begin
      oALU_Control = {1'b0, r_funct3};
    end

    if (w_is_il) begin
      oRegWrDataSel = 2'd1;
    end else if (w_is_lui) begin
      oRegWrDataSel = 2'd2;
    end else if (w_is_jal || w_is_jalr) begin
      oRegWrDataSel = 2'd3;
    end

    if (w_is_jal) begin
      oPC_Sel = 2'd1;
    end else if (w_is_jalr) begin
      oPC_Sel = 2'd2;
    end else if (w_is_b && (r_state == ST_EXECUTE) && iBtaken) begin
      oPC_Sel = 2'd1;
    end
  end

  // Next state and enables. Enables are held low combinationally while iRst
  // is high, otherwise the reset state (FETCH) would already raise oIR_En.
  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_set_buserr  = 1'b0;
    oIR_En        = 1'b0;
    oPC_En        = 1'b0;
    oRegWrEn      = 1'b0;
    oData_Req     = 1'b0;
    oData_WrEn    = 1'b0;

    if (!iRst) begin
      case (r_state)
        ST_FETCH: begin
          oIR_En = 1'b1;
          w_next = ST_DECODE;
        end
        ST_DECODE: begin
          if (w_legal) begin
            w_next = ST_EXECUTE;
          end else begin
            w_next        = ST_HALT;
            w_set_illegal = 1'b1;
          end
        end
        ST_EXECUTE: begin
          if (w_is_b) begin
            oPC_En = 1'b1;
            w_next = ST_FETCH;
          end else if (w_is_il || w_is_s) begin
            w_next = ST_MEM;
          end else begin
            w_next = ST_WB;
          end
        end
        ST_MEM: begin
          oData_Req  = 1'b1;
          oData_WrEn = w_is_s;
          // An ack takes priority, even on the last counted cycle.
          if (iData_Ack) begin
            if (w_is_s) begin
              oPC_En = 1'b1;
              w_next = ST_FETCH;
            end else begin
              w_next = ST_WB;
            end
          end else if (r_cnt == c_CNT_LAST) begin
            w_next       = ST_HALT;
            w_set_buserr = 1'b1;
          end
        end
        ST_WB: begin
          oRegWrEn = 1'b1;
          oPC_En   = 1'b1;
          w_next   = ST_FETCH;
        end
        ST_HALT: begin
          w_next = ST_HALT;
        end
        default: begin
          w_next = ST_FETCH;
        end
      endcase
    end
  end

  assign oIllegal = r_illegal;
  assign oBusErr  = r_buserr;

endmodule
`default_nettype wire

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have a parameter: DATA_TIMEOUT, default 16, the maximum number of cycles in MEM without iData_Ack before a fault is raised.
REQ-002 SHALL have port iClk, input, 1 bit: clock; all state updates occur on the rising edge.
REQ-003 SHALL have port iRst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port iInst_Code, input, 32 bits: the instruction at the current PC.
REQ-005 SHALL have port iBtaken, input, 1 bit: branch comparison result from the ALU.
REQ-006 SHALL have port iData_Ack, input, 1 bit: data memory completes the pending access.
REQ-007 SHALL have port oIR_En, output, 1 bit: loads the instruction register.
REQ-008 SHALL have port oPC_En, output, 1 bit: loads the PC.
REQ-009 SHALL have port oPC_Sel, output, 2 bits: 0 = PC+4, 1 = PC+imm, 2 = ALU result.
REQ-010 SHALL have port oALU_Control, output, 4 bits: ALU operation.
REQ-011 SHALL have port oALUSrcMuxSel1, output, 1 bit: 0 = rs1, 1 = PC.
REQ-012 SHALL have port oALUSrcMuxSel2, output, 1 bit: 0 = rs2, 1 = imm.
REQ-013 SHALL have port oRegWrDataSel, output, 2 bits: 0 = ALU, 1 = memory read data, 2 = imm, 3 = PC+4.
REQ-014 SHALL have port oRegWrEn, output, 1 bit: register file write enable.
REQ-015 SHALL have port oData_Req, output, 1 bit: data access request.
REQ-016 SHALL have port oData_WrEn, output, 1 bit: 1 = store.
REQ-017 SHALL have port oData_Size, output, 3 bits: funct3 of the load/store.
REQ-018 SHALL have port oIllegal, output, 1 bit: unsupported opcode halt.
REQ-019 SHALL have port oBusErr, output, 1 bit: data timeout halt.

Function
REQ-020 SHALL implement the FSM states FETCH, DECODE, EXECUTE, MEM, WB, HALT.
REQ-021 SHALL in FETCH assert oIR_En for one cycle, latch iInst_Code internally and go to DECODE.
REQ-022 SHALL in DECODE check the opcode: R 0110011, IL 0000011, I 0010011, S 0100011, B 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111; any other opcode goes to HALT with oIllegal=1; a legal opcode goes to EXECUTE.
REQ-023 SHALL drive every datapath select and oALU_Control from the latched instruction only, holding them constant from DECODE through the last cycle of the instruction.
REQ-024 SHALL encode oALU_Control as: R-type {funct7[5], funct3}; I-type {funct3==101 ? funct7[5] : 0, funct3}; B-type {0, funct3}; IL, S, AUIPC and JALR 4'b0000 (ADD).
REQ-025 SHALL set oALUSrcMuxSel2=1 for I, IL, S, JALR and AUIPC, and 0 otherwise; oALUSrcMuxSel1=1 only for AUIPC.
REQ-026 SHALL handle EXECUTE as: B asserts oPC_En with oPC_Sel = iBtaken ? 1 : 0 and goes to FETCH; IL and S go to MEM; all others go to WB.
REQ-027 SHALL in MEM hold oData_Req=1 and oData_Size=funct3 until iData_Ack, with oData_WrEn=1 only for S.
REQ-028 SHALL on iData_Ack in MEM drop oData_Req the next cycle; S asserts oPC_En with oPC_Sel=0 in that same ack cycle and goes to FETCH; IL goes to WB.
REQ-029 SHALL count MEM cycles and, at DATA_TIMEOUT cycles without iData_Ack, go to HALT with oBusErr=1 and oData_Req=0; an ack on the final counted cycle wins.
REQ-030 SHALL in WB assert oRegWrEn and oPC_En for one cycle and go to FETCH.
REQ-031 SHALL select in WB: R/I oRegWrDataSel=0, oPC_Sel=0; IL 1/0; LUI 2/0; AUIPC 0/0; JAL 3/1; JALR 3/2.
REQ-032 SHALL produce these latencies: B 3 cycles; R/I/LUI/AUIPC/JAL/JALR 4 cycles; S 3+N cycles; IL 4+N cycles, where N ≥ 1 is MEM cycles including the ack cycle.
REQ-033 SHALL assert oPC_En and oRegWrEn at most once per instruction, and never both oRegWrEn and oData_Req in the same cycle.
REQ-034 SHALL remain in HALT, with all enables 0, until iRst.

Reset
REQ-035 SHALL on iRst immediately force state FETCH, all enables, oData_Req, oIllegal and oBusErr to 0, all selects 0, oALU_Control 4'b0000, and the timeout counter to 0, including during MEM.
REQ-036 SHALL begin FETCH on the first rising edge after iRst deasserts.

Verification
REQ-037 SHALL verify: add x3,x1,x2 (0x002081B3) -> FETCH/DECODE/EXECUTE/WB; oALU_Control=0000, oRegWrDataSel=0; oRegWrEn=oPC_En=1 in cycle 4 only.
REQ-038 SHALL verify: beq (0x00208463), iBtaken=1 -> oPC_En=1 with oPC_Sel=1 in cycle 3, next state FETCH; with iBtaken=0 -> oPC_Sel=0.
REQ-039 SHALL verify: lw (0x0040A183), ack 3 cycles after MEM entry -> oData_Req high 3 cycles, oData_WrEn=0, oData_Size=010, then WB with oRegWrDataSel=1; total 7 cycles.
REQ-040 SHALL verify: sw (0x0020A223) with no ack, DATA_TIMEOUT=16 -> after 16 MEM cycles oBusErr=1, oData_Req=0, HALT persists.
REQ-041 SHALL verify: opcode 0x0000007F -> HALT after DECODE, oIllegal=1, no oPC_En or oRegWrEn ever; iRst pulse clears it and FETCH resumes.
REQ-042 SHALL verify: iRst asserted mid-MEM without a clock edge -> oData_Req=0 immediately; after release, FETCH with oIR_En=1.
